// File: rtl/rpsc_pkg.sv
// Shared types and defaults for the RPSC permit/interlock sequencer.
package rpsc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        WARMUP  = 3'd2,
        RUN     = 3'd3,
        TRIP    = 3'd4
    } rpsc_state_t;

    localparam int unsigned RPSC_N_FLT_DEF   = 7;
    localparam int unsigned RPSC_T_PERM_DEF  = 4;
    localparam int unsigned RPSC_T_DELAY_DEF = 16;

    // Timer width able to hold the larger of the two programmed delays.
    function automatic int unsigned rpsc_cnt_w(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rpsc_interlock_seq_if.sv
// Front-panel/status inputs and PS drive/status outputs of one sequencer instance.
interface rpsc_interlock_seq_if
    import rpsc_pkg::*;
#(
    parameter int unsigned N_FLT = RPSC_N_FLT_DEF
);
    logic [N_FLT-1:0] flt_i;
    logic [N_FLT-1:0] flt_mask;
    logic             not_g1_ok_i;
    logic             fan_on_i;
    logic             ps_req_i;
    logic             ack_i;
    logic             i_high_i;
    logic             u_low_i;

    logic             not_alarm_o;
    logic             perm_n_o;
    logic             ps_on_n_o;
    logic             delay_done_o;
    logic             not_ok_o;
    logic             i_high_n_o;
    logic             u_low_n_o;
    logic [N_FLT-1:0] first_fault_o;
    logic [2:0]       state_o;

    modport master (
        output flt_i, flt_mask, not_g1_ok_i, fan_on_i, ps_req_i, ack_i, i_high_i, u_low_i,
        input  not_alarm_o, perm_n_o, ps_on_n_o, delay_done_o, not_ok_o,
               i_high_n_o, u_low_n_o, first_fault_o, state_o
    );

    modport slave (
        input  flt_i, flt_mask, not_g1_ok_i, fan_on_i, ps_req_i, ack_i, i_high_i, u_low_i,
        output not_alarm_o, perm_n_o, ps_on_n_o, delay_done_o, not_ok_o,
               i_high_n_o, u_low_n_o, first_fault_o, state_o
    );
endinterface

// File: rtl/rpsc_fault_latch.sv
// Fault latch with first-trip snapshot; snapshot survives the acknowledge.
module rpsc_fault_latch
    import rpsc_pkg::*;
#(
    parameter int unsigned N_FLT = RPSC_N_FLT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             clr,
    input  logic [N_FLT-1:0] act_flt,
    output logic             latched,
    output logic [N_FLT-1:0] first_fault
);

    always_ff @(posedge clk) begin
        if (reset) begin
            latched     <= 1'b0;
            first_fault <= '0;
        end else if (set && !latched) begin
            latched     <= 1'b1;
            first_fault <= act_flt;
        end else if (clr) begin
            latched     <= 1'b0;
        end
    end

endmodule

// File: rtl/rpsc_interlock_seq.sv
// Per-supply start sequencer: qualify request, time warm-up, declare RUN, latch faults.
module rpsc_interlock_seq
    import rpsc_pkg::*;
#(
    parameter int unsigned N_FLT   = RPSC_N_FLT_DEF,
    parameter int unsigned T_PERM  = RPSC_T_PERM_DEF,
    parameter int unsigned T_DELAY = RPSC_T_DELAY_DEF,
    parameter int unsigned CNT_W   = rpsc_cnt_w(T_PERM, T_DELAY)
) (
    input  logic                  clk,
    input  logic                  reset,
    rpsc_interlock_seq_if.slave   bus
);

    rpsc_state_t      state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    logic [N_FLT-1:0] act_flt_c;
    logic             any_flt_c;
    logic             permit_c;
    logic             stage_on_d_c;
    logic             latch_set_c;
    logic             latch_clr_c;

    logic             latched;
    logic [N_FLT-1:0] first_fault;

    logic perm_n_q, ps_on_n_q, delay_done_q, not_ok_q, i_high_n_q, u_low_n_q;

    assign act_flt_c = bus.flt_i & ~bus.flt_mask;
    assign any_flt_c = |act_flt_c;
    assign permit_c  = !any_flt_c && !latched && !bus.not_g1_ok_i && !bus.fan_on_i;

    // State register and shared delay timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state: fault beats interlock/request loss, which beats timer expiry.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            IDLE: begin
                if (any_flt_c)                    state_d = TRIP;
                else if (permit_c && bus.ps_req_i) state_d = QUALIFY;
            end
            QUALIFY: begin
                if (any_flt_c)                              state_d = TRIP;
                else if (!permit_c || !bus.ps_req_i)        state_d = IDLE;
                else if (timer_q == CNT_W'(T_PERM - 1))     state_d = WARMUP;
                else                                        timer_d = timer_q + CNT_W'(1);
            end
            WARMUP: begin
                if (any_flt_c)                              state_d = TRIP;
                else if (!permit_c || !bus.ps_req_i)        state_d = IDLE;
                else if (timer_q == CNT_W'(T_DELAY - 1))    state_d = RUN;
                else                                        timer_d = timer_q + CNT_W'(1);
            end
            RUN: begin
                if (any_flt_c)                              state_d = TRIP;
                else if (!permit_c || !bus.ps_req_i)        state_d = IDLE;
            end
            TRIP: begin
                if (bus.ack_i && !any_flt_c)                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign latch_set_c  = (state_d == TRIP) && (state_q != TRIP);
    assign latch_clr_c  = (state_q == TRIP) && (state_d == IDLE);
    assign stage_on_d_c = (state_d == WARMUP) || (state_d == RUN);

    rpsc_fault_latch #(.N_FLT(N_FLT)) u_fault_latch (
        .clk         (clk),
        .reset       (reset),
        .set         (latch_set_c),
        .clr         (latch_clr_c),
        .act_flt     (act_flt_c),
        .latched     (latched),
        .first_fault (first_fault)
    );

    // Output registers decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            perm_n_q     <= 1'b1;
            ps_on_n_q    <= 1'b1;
            delay_done_q <= 1'b0;
            not_ok_q     <= 1'b1;
            i_high_n_q   <= 1'b1;
            u_low_n_q    <= 1'b1;
        end else begin
            perm_n_q     <= !permit_c;
            ps_on_n_q    <= !stage_on_d_c;
            delay_done_q <= (state_d == RUN);
            not_ok_q     <= (state_d != RUN);
            i_high_n_q   <= !(stage_on_d_c && bus.i_high_i);
            u_low_n_q    <= !(stage_on_d_c && bus.u_low_i);
        end
    end

    assign bus.not_alarm_o   = !latched;
    assign bus.perm_n_o      = perm_n_q;
    assign bus.ps_on_n_o     = ps_on_n_q;
    assign bus.delay_done_o  = delay_done_q;
    assign bus.not_ok_o      = not_ok_q;
    assign bus.i_high_n_o    = i_high_n_q;
    assign bus.u_low_n_o     = u_low_n_q;
    assign bus.first_fault_o = first_fault;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_rpsc_interlock_seq.sv
// Self-checking bench: directed scenarios plus random traffic against a count-based model.
module tb_rpsc_interlock_seq;

    localparam int unsigned N  = 7;
    localparam int unsigned TP = 4;
    localparam int unsigned TD = 16;
    localparam logic [16:0] RST_VEC = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rpsc_interlock_seq_if #(.N_FLT(N)) bus ();

    rpsc_interlock_seq #(.N_FLT(N), .T_PERM(TP), .T_DELAY(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: a fault flag plus a count of consecutive clean, requested edges.
    bit          m_trip;
    logic [N-1:0] m_first;
    int          m_cnt;
    bit          m_perm_n, m_ihn, m_uln;
    logic [16:0] exp_vec;
    logic [16:0] dut_vec;

    assign dut_vec = {bus.state_o, bus.not_alarm_o, bus.perm_n_o, bus.ps_on_n_o,
                      bus.delay_done_o, bus.not_ok_o, bus.i_high_n_o, bus.u_low_n_o,
                      bus.first_fault_o};

    function automatic int phase();
        if (m_trip)                 return 4;
        if (m_cnt == 0)             return 0;
        if (m_cnt <= int'(TP))      return 1;
        if (m_cnt <= int'(TP + TD)) return 2;
        return 3;
    endfunction

    task automatic step();
        logic [N-1:0] act;
        int ph;
        bit stage;
        @(posedge clk);
        act = bus.flt_i & ~bus.flt_mask;
        if (reset) begin
            m_trip = 0; m_first = '0; m_cnt = 0;
            m_perm_n = 1; m_ihn = 1; m_uln = 1;
        end else begin
            m_perm_n = !((act == '0) && !m_trip && !bus.not_g1_ok_i && !bus.fan_on_i);
            if (m_trip) begin
                if (bus.ack_i && act == '0) begin m_trip = 0; m_cnt = 0; end
            end else if (act != '0) begin
                m_trip = 1; m_first = act; m_cnt = 0;
            end else if (bus.not_g1_ok_i || bus.fan_on_i || !bus.ps_req_i) begin
                m_cnt = 0;
            end else if (m_cnt < int'(TP + TD + 1)) begin
                m_cnt++;
            end
            ph    = phase();
            stage = (ph == 2) || (ph == 3);
            m_ihn = !(stage && bus.i_high_i);
            m_uln = !(stage && bus.u_low_i);
        end
        ph    = phase();
        stage = (ph == 2) || (ph == 3);
        exp_vec = {3'(ph), !m_trip, m_perm_n, !stage, ph == 3, ph != 3, m_ihn, m_uln, m_first};
        #1;
    endtask

    task automatic clear_inputs();
        bus.flt_i = '0; bus.flt_mask = '0; bus.not_g1_ok_i = 0; bus.fan_on_i = 0;
        bus.ps_req_i = 0; bus.ack_i = 0; bus.i_high_i = 0; bus.u_low_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        repeat (2) begin
            step();
            checks++;
            if (dut_vec !== RST_VEC) begin
                errors++; $display("FAIL reset_vals got=%h exp=%h", dut_vec, RST_VEC);
            end
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec);
            end
        end
        reset = 0;
    endtask

    task automatic test_sequence(input string tag);
        logic [2:0] est;
        bus.ps_req_i = 1;
        for (int e = 0; e <= int'(TP + TD); e++) begin
            step();
            est = (e < int'(TP)) ? 3'd1 : (e < int'(TP + TD)) ? 3'd2 : 3'd3;
            checks++;
            if (bus.state_o !== est || bus.ps_on_n_o !== (est == 3'd1) ||
                bus.delay_done_o !== (est == 3'd3) || bus.not_ok_o !== (est != 3'd3)) begin
                errors++;
                $display("FAIL %s edge=%0d st=%0d ps_on_n=%b dd=%b nok=%b exp_st=%0d",
                         tag, e, bus.state_o, bus.ps_on_n_o, bus.delay_done_o, bus.not_ok_o, est);
            end
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL %s_model edge=%0d got=%h exp=%h", tag, e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_fault_ack();
        bus.flt_i = 7'b0000100;
        step();
        bus.flt_i = '0;
        checks++;
        if (bus.state_o !== 3'd4 || bus.not_alarm_o !== 1'b0 || bus.first_fault_o !== 7'b0000100) begin
            errors++;
            $display("FAIL trip st=%0d na=%b ff=%b exp st=4 na=0 ff=0000100",
                     bus.state_o, bus.not_alarm_o, bus.first_fault_o);
        end
        step();
        checks++;
        if (bus.state_o !== 3'd4) begin
            errors++; $display("FAIL trip_hold st=%0d exp=4", bus.state_o);
        end
        bus.ack_i = 1;
        step();
        bus.ack_i = 0;
        checks++;
        if (bus.state_o !== 3'd0 || bus.not_alarm_o !== 1'b1 || bus.first_fault_o !== 7'b0000100) begin
            errors++;
            $display("FAIL ack_release st=%0d na=%b ff=%b exp st=0 na=1 ff=0000100",
                     bus.state_o, bus.not_alarm_o, bus.first_fault_o);
        end
        test_sequence("reseq");
    endtask

    task automatic test_multi_fault();
        bus.ps_req_i = 0;
        step();
        bus.ps_req_i = 1;
        repeat (TP + 1) step();
        checks++;
        if (bus.state_o !== 3'd2) begin
            errors++; $display("FAIL mf_warmup st=%0d exp=2", bus.state_o);
        end
        bus.flt_i = 7'b0010001;
        step();
        checks++;
        if (bus.state_o !== 3'd4 || bus.first_fault_o !== 7'b0010001) begin
            errors++; $display("FAIL mf_first st=%0d ff=%b exp st=4 ff=0010001", bus.state_o, bus.first_fault_o);
        end
        bus.flt_i = 7'b0000001;
        bus.ack_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.state_o !== 3'd4 || dut_vec !== exp_vec) begin
                errors++; $display("FAIL mf_ack_blocked i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
        end
        bus.flt_i = '0;
        step();
        bus.ack_i = 0;
        checks++;
        if (bus.state_o !== 3'd0 || bus.not_alarm_o !== 1'b1) begin
            errors++; $display("FAIL mf_release st=%0d na=%b exp st=0 na=1", bus.state_o, bus.not_alarm_o);
        end
    endtask

    task automatic test_interlock();
        bus.ps_req_i = 0;
        step();
        bus.ps_req_i = 1;
        repeat (3) step();
        bus.fan_on_i = 1;
        step();
        checks++;
        if (bus.state_o !== 3'd0 || bus.not_alarm_o !== 1'b1 || bus.perm_n_o !== 1'b1) begin
            errors++;
            $display("FAIL fan_drop st=%0d na=%b pn=%b exp st=0 na=1 pn=1",
                     bus.state_o, bus.not_alarm_o, bus.perm_n_o);
        end
        bus.fan_on_i = 0;
        for (int e = 0; e <= int'(TP); e++) begin
            step();
            checks++;
            if (bus.state_o !== ((e < int'(TP)) ? 3'd1 : 3'd2) || dut_vec !== exp_vec) begin
                errors++; $display("FAIL requalify edge=%0d got=%h exp=%h", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_mask_monitor();
        bus.ps_req_i = 0;
        step();
        bus.flt_mask = 7'b0100000;
        bus.flt_i    = 7'b0100000;
        bus.i_high_i = 1;
        test_sequence("masked");
        checks++;
        if (bus.not_alarm_o !== 1'b1 || bus.i_high_n_o !== 1'b0) begin
            errors++; $display("FAIL masked_run na=%b ihn=%b exp na=1 ihn=0", bus.not_alarm_o, bus.i_high_n_o);
        end
        bus.u_low_i = 1;
        step();
        checks++;
        if (bus.u_low_n_o !== 1'b0 || bus.i_high_n_o !== 1'b0) begin
            errors++; $display("FAIL run_mon uln=%b ihn=%b exp 0 0", bus.u_low_n_o, bus.i_high_n_o);
        end
        bus.ps_req_i = 0;
        step();
        checks++;
        if (bus.state_o !== 3'd0 || bus.i_high_n_o !== 1'b1 || bus.u_low_n_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_mon st=%0d ihn=%b uln=%b exp st=0 1 1", bus.state_o, bus.i_high_n_o, bus.u_low_n_o);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bus.flt_i = 7'b0000010;
        step();
        checks++;
        if (bus.state_o !== 3'd4) begin
            errors++; $display("FAIL rst_pre_trip st=%0d exp=4", bus.state_o);
        end
        reset = 1;
        step();
        reset = 0;
        bus.flt_i = '0;
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++; $display("FAIL rst_in_trip got=%h exp=%h", dut_vec, RST_VEC);
        end
        bus.ps_req_i = 1;
        repeat (TP + 3) step();
        checks++;
        if (bus.state_o !== 3'd2) begin
            errors++; $display("FAIL rst_pre_warm st=%0d exp=2", bus.state_o);
        end
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++; $display("FAIL rst_in_warmup got=%h exp=%h", dut_vec, RST_VEC);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            bus.flt_i       = ($urandom_range(0, 24) == 0) ? 7'($urandom) : '0;
            if ($urandom_range(0, 99) == 0) bus.flt_mask = 7'($urandom) & 7'($urandom);
            bus.not_g1_ok_i = ($urandom_range(0, 59) == 0);
            bus.fan_on_i    = ($urandom_range(0, 59) == 0);
            bus.ps_req_i    = ($urandom_range(0, 39) != 0);
            bus.ack_i       = ($urandom_range(0, 3) == 0);
            bus.i_high_i    = 1'($urandom);
            bus.u_low_i     = 1'($urandom);
            reset           = ($urandom_range(0, 299) == 0);
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
        end
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_sequence("seq");
        test_fault_ack();
        test_multi_fault();
        test_interlock();
        test_mask_monitor();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
